// File: rtl/pic_load_ctrl.sv
// -----------------------------------------------------------------------------
// pic_load_ctrl
// Write-side controller for the double-buffered image RAM behind the TFT
// picture overlay. Parses framed UART bytes (header HDR0 HDR1, IMAGE_SIZE pixel
// bytes, 8-bit additive checksum), writes the pixels into the hidden bank and
// swaps the displayed bank on the next vs_pulse after a good checksum.
//
// Ports
//   sys_clk    in   1   system clock
//   sys_rst_n  in   1   asynchronous active-low reset
//   pi_flag    in   1   1-cycle strobe: pi_data valid
//   pi_data    in   8   received byte
//   vs_pulse   in   1   1-cycle frame-start pulse (sys_clk domain)
//   ram_wren   out  1   RAM write enable
//   ram_waddr  out  15  {bank, pixel_index[13:0]}
//   ram_wdata  out  8   RAM write data
//   disp_bank  out  1   bank currently shown; writes go to ~disp_bank
//   frame_ok   out  1   1-cycle pulse: bank swap performed
//   frame_err  out  1   1-cycle pulse: checksum mismatch or rx timeout
//   busy       out  1   high whenever a frame is in progress or awaiting swap
// -----------------------------------------------------------------------------
module pic_load_ctrl #(
    parameter int          IMAGE_SIZE  = 10000,  // pixel bytes per frame, max 16384
    parameter int          TIMEOUT_CYC = 52080,  // rx silence that aborts a frame
    parameter logic [7:0]  HDR0        = 8'h55,
    parameter logic [7:0]  HDR1        = 8'hAA
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        pi_flag,
    input  logic [7:0]  pi_data,
    input  logic        vs_pulse,
    output logic        ram_wren,
    output logic [14:0] ram_waddr,
    output logic [7:0]  ram_wdata,
    output logic        disp_bank,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        busy
);

    localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [13:0] LAST_IDX = 14'(IMAGE_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_SWAP
    } state_t;

    state_t          state_q, state_d;
    logic [13:0]     idx_q, idx_d;
    logic [7:0]      csum_q, csum_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            ram_wren_q, ram_wren_d;
    logic [14:0]     ram_waddr_q, ram_waddr_d;
    logic [7:0]      ram_wdata_q, ram_wdata_d;
    logic            disp_bank_q, disp_bank_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_err_q, frame_err_d;
    logic            busy_q, busy_d;

    logic            timed;
    logic            tmo_hit;

    // Rx-silence watchdog runs only while a frame is being received.
    assign timed   = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign tmo_hit = timed && !pi_flag && (tmo_q == TMO_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        ram_wren_d  = 1'b0;
        ram_waddr_d = ram_waddr_q;
        ram_wdata_d = ram_wdata_q;
        disp_bank_d = disp_bank_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pi_flag && pi_data == HDR0) state_d = S_HDR;
            end
            S_HDR: begin
                if (pi_flag) begin
                    if (pi_data == HDR1) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                        csum_d  = '0;
                    end else if (pi_data != HDR0) begin
                        // A repeated HDR0 keeps us aligned on the header.
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (pi_flag) begin
                    ram_wren_d  = 1'b1;
                    ram_waddr_d = {~disp_bank_q, idx_q};
                    ram_wdata_d = pi_data;
                    csum_d      = csum_q + pi_data;
                    idx_d       = idx_q + 14'd1;
                    if (idx_q == LAST_IDX) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (pi_flag) begin
                    if (pi_data == csum_q) begin
                        state_d = S_SWAP;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_SWAP: begin
                // Rx bytes are dropped until the display takes the new bank.
                if (vs_pulse) begin
                    disp_bank_d = ~disp_bank_q;
                    frame_ok_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (tmo_hit) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
        end

        if (pi_flag || (state_d != state_q) || !timed) tmo_d = '0;
        else                                          tmo_d = tmo_q + TW'(1);

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            csum_q      <= '0;
            tmo_q       <= '0;
            ram_wren_q  <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
            disp_bank_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            tmo_q       <= tmo_d;
            ram_wren_q  <= ram_wren_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
            disp_bank_q <= disp_bank_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign ram_wren  = ram_wren_q;
    assign ram_waddr = ram_waddr_q;
    assign ram_wdata = ram_wdata_q;
    assign disp_bank = disp_bank_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
